// File: rtl/key_debounce.sv
// Per-key 2-FF synchroniser plus counter debounce for active-low pushbuttons.
// Optional auto-repeat on held keys is built when KEY_AUTOREPEAT_EN is defined.
//
//   state  | meaning
//   UP     | stable released, waiting for s2 to go low
//   CHK_DN | s2 low, counting toward press acceptance
//   DOWN   | stable pressed, waiting for s2 to go high
//   CHK_UP | s2 high, counting toward release acceptance
module key_debounce #(
    parameter int NUM_KEYS             = 4,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY_CYCLES < 2 || REPEAT_PERIOD_CYCLES < 2) begin : g_bad_repeat
        $error("key_debounce: repeat intervals must be at least 2");
    end

    // Bit 1 of the encoding doubles as "stable pressed".
    typedef enum logic [1:0] {
        UP     = 2'b00,
        CHK_DN = 2'b01,
        DOWN   = 2'b10,
        CHK_UP = 2'b11
    } state_t;

    logic [NUM_KEYS-1:0] sync_1, sync_2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= key_in;
            sync_2 <= sync_1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_t        state, state_nxt;
        logic [CW-1:0] cnt, cnt_nxt;
        logic          accept_press, accept_release;
        logic          press_q, release_q;
        logic          rpt_hit, blip;

        always_comb begin
            state_nxt      = state;
            cnt_nxt        = cnt;
            accept_press   = 1'b0;
            accept_release = 1'b0;
            case (state)
                UP: begin
                    if (!sync_2[k]) begin
                        state_nxt = CHK_DN;
                        cnt_nxt   = CW'(1);
                    end
                end
                CHK_DN: begin
                    if (sync_2[k]) begin
                        state_nxt = UP;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt    = DOWN;
                        cnt_nxt      = '0;
                        accept_press = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (sync_2[k]) begin
                        state_nxt = CHK_UP;
                        cnt_nxt   = CW'(1);
                    end
                end
                CHK_UP: begin
                    if (!sync_2[k]) begin
                        state_nxt = DOWN;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt      = UP;
                        cnt_nxt        = '0;
                        accept_release = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = UP;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state     <= UP;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                press_q   <= accept_press | rpt_hit;
                release_q <= accept_release;
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
        localparam int RW = $clog2(RPT_MAX);
        localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY_CYCLES - 1);
        localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD_CYCLES - 1);

        logic [RW-1:0] rpt_cnt;
        logic          rpt_first;
        logic          enter_down;

        assign enter_down = (state_nxt == DOWN) && (state != DOWN);
        // A release accepted this cycle wins over a coincident repeat.
        assign rpt_hit = state[1] && !accept_release &&
                         (rpt_cnt == (rpt_first ? RPT_FIRST : RPT_NEXT));

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rpt_cnt   <= '0;
                rpt_first <= 1'b1;
                blip      <= 1'b0;
            end else begin
                blip <= rpt_hit;
                if (!state[1] || state_nxt == UP) begin
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b1;
                end else if (rpt_hit) begin
                    rpt_cnt   <= '0;
                    rpt_first <= 1'b0;
                end else if (enter_down) begin
                    rpt_cnt <= '0;
                end else begin
                    rpt_cnt <= rpt_cnt + 1'b1;
                end
            end
        end
`else
        assign rpt_hit = 1'b0;
        assign blip    = 1'b0;
`endif

        assign key_out[k]       = ~state[1] | blip;
        assign press_pulse[k]   = press_q;
        assign release_pulse[k] = release_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected output events are queued when
// stimulus is driven and matched against every observed output change.
module tb_key_debounce;

    localparam int NK = 4;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RP = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_out, press_pulse, release_pulse;

    key_debounce #(
        .NUM_KEYS            (NK),
        .DEBOUNCE_CYCLES     (DB),
        .REPEAT_DELAY_CYCLES (RD),
        .REPEAT_PERIOD_CYCLES(RP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [11:0] val;
    } evt_t;

    evt_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    logic [NK-1:0] last_ko;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int at, input logic [3:0] ko, input logic [3:0] pp,
                              input logic [3:0] rp);
        evt_t e;
        e.at  = at;
        e.val = {ko, pp, rp};
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        tick(15);
        check_val(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Every cycle with a pulse or a key_out change is one event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (press_pulse != '0 || release_pulse != '0 || key_out != last_ko) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_extra", 32'(sb_q.size()), 32'd1);
                    $display("  unexpected event ko=%b pp=%b rp=%b", key_out, press_pulse, release_pulse);
                end else begin
                    evt_t e;
                    e = sb_q.pop_front();
                    check_val("evt_cyc", 32'(cyc), 32'(e.at));
                    check_val("evt_val", {20'h0, key_out, press_pulse, release_pulse}, {20'h0, e.val});
                end
            end
            last_ko = key_out;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n = 1'b0;
        key_in  = 4'b0000;

        // reset held with all keys low
        repeat (3) begin
            tick(1);
            check_val("rst_ko", 32'(key_out), 32'hF);
            check_val("rst_pulse", {24'h0, press_pulse, release_pulse}, 32'h0);
        end
        last_ko = key_out;
        mon_en  = 1'b1;
        reset_n = 1'b1;
        t = cyc;
        expect_evt(t + 10, 4'b0000, 4'b1111, 4'b0000);
        repeat (9) begin
            tick(1);
            check_val("post_rst_ko", 32'(key_out), 32'hF);
        end
        tick(6);
        key_in = 4'b1111;
        expect_evt(cyc + 10, 4'b1111, 4'b0000, 4'b1111);
        drain("sb_empty_rst");

        // clean press and release on key 0
        key_in[0] = 1'b0;
        expect_evt(cyc + 10, 4'b1110, 4'b0001, 4'b0000);
        tick(20);
        key_in[0] = 1'b1;
        expect_evt(cyc + 10, 4'b1111, 4'b0000, 4'b0001);
        drain("sb_empty_clean");

        // bounce on key 1: low 5, high 2, then steady low
        key_in[1] = 1'b0;
        tick(5);
        key_in[1] = 1'b1;
        tick(2);
        key_in[1] = 1'b0;
        expect_evt(cyc + 10, 4'b1101, 4'b0010, 4'b0000);
        tick(20);
        key_in[1] = 1'b1;
        expect_evt(cyc + 10, 4'b1111, 4'b0000, 4'b0010);
        drain("sb_empty_bounce");

        // keys 2 and 3 together
        key_in[3:2] = 2'b00;
        expect_evt(cyc + 10, 4'b0011, 4'b1100, 4'b0000);
        tick(20);
        key_in = 4'b1111;
        expect_evt(cyc + 10, 4'b1111, 4'b0000, 4'b1100);
        drain("sb_empty_multi");

        // reset in the middle of a press debounce
        key_in[0] = 1'b0;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        check_val("midrst_ko", 32'(key_out), 32'hF);
        check_val("midrst_pulse", {24'h0, press_pulse, release_pulse}, 32'h0);
        reset_n = 1'b1;
        expect_evt(cyc + 10, 4'b1110, 4'b0001, 4'b0000);
        tick(20);
        key_in[0] = 1'b1;
        expect_evt(cyc + 10, 4'b1111, 4'b0000, 4'b0001);
        drain("sb_empty_midrst");

        // long hold on key 0
        key_in[0] = 1'b0;
        t = cyc;
        expect_evt(t + 10, 4'b1110, 4'b0001, 4'b0000);
`ifdef KEY_AUTOREPEAT_EN
        for (int r = 10 + RD; r < 110; r += RP) begin
            expect_evt(t + r, 4'b1111, 4'b0001, 4'b0000);
            expect_evt(t + r + 1, 4'b1110, 4'b0000, 4'b0000);
        end
`endif
        tick(100);
        key_in[0] = 1'b1;
        expect_evt(t + 110, 4'b1111, 4'b0000, 4'b0001);
        drain("sb_empty_hold");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
